wb_result_sel: RTL and testbench

- Parametrised, registered writeback result selector for the pipelined core datapath. Replaces the single-cycle combinational result mux.
- Selects one of NSRC result sources per instruction and holds the chosen value in a one-entry output register with valid/ready handshake.
- Stalls on loads until memory read data is valid.
- Flags illegal selects and suppresses writes to x0.
- Sits between the execute/memory stage and the register-file write port.

---
 rtl/wb_result_sel.sv | 157 +++++++++++++++
 tb/tb_wb_result_sel.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_sel.sv
// wb_result_sel: registered writeback result selector with a one-entry output
// register, valid/ready handshake, load-data stall, illegal-select flagging and
// x0 write suppression.
// Optional performance counters are compiled in when WB_PERF_EN is defined.
module wb_result_sel #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NSRC     = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned LOAD_SRC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [4:0]           rd,
    input  logic                 reg_write,
    input  logic                 mem_rvalid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic [4:0]           out_rd,
    output logic                 out_reg_write,
    output logic                 sel_err
`ifdef WB_PERF_EN
    ,
    output logic [31:0]          perf_retired,
    output logic [31:0]          perf_stall
`endif
);

    localparam logic [0:0] ACCEPT    = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic            valid_nxt;
    logic [XLEN-1:0] result_nxt;
    logic [4:0]      out_rd_nxt;
    logic            out_reg_write_nxt;
    logic            sel_err_nxt;
    logic [4:0]      pend_rd;
    logic [4:0]      pend_rd_nxt;
    logic            pend_reg_write;
    logic            pend_reg_write_nxt;

    logic            sel_legal;
    logic            sel_is_load;
    logic            out_free;
    logic            transfer;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] load_data;

    assign sel_legal   = 32'(sel) < NSRC;
    assign sel_is_load = 32'(sel) == LOAD_SRC;
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = (state == ACCEPT) && out_free;
    assign transfer    = in_valid && in_ready;
    assign load_data   = src_data[LOAD_SRC*XLEN +: XLEN];

    // Source mux; out-of-range selects yield zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(sel) == i) begin
                sel_data = src_data[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state and next output-register contents.
    always_comb begin
        state_nxt          = state;
        valid_nxt          = out_valid;
        result_nxt         = result;
        out_rd_nxt         = out_rd;
        out_reg_write_nxt  = out_reg_write;
        sel_err_nxt        = sel_err;
        pend_rd_nxt        = pend_rd;
        pend_reg_write_nxt = pend_reg_write;

        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            ACCEPT: begin
                if (transfer) begin
                    if (!sel_is_load || mem_rvalid) begin
                        valid_nxt         = 1'b1;
                        result_nxt        = sel_legal ? sel_data : '0;
                        out_rd_nxt        = rd;
                        out_reg_write_nxt = reg_write && (rd != 5'd0) && sel_legal;
                        sel_err_nxt       = !sel_legal;
                    end else begin
                        pend_rd_nxt        = rd;
                        pend_reg_write_nxt = reg_write;
                        state_nxt          = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid && out_free) begin
                    valid_nxt         = 1'b1;
                    result_nxt        = load_data;
                    out_rd_nxt        = pend_rd;
                    out_reg_write_nxt = pend_reg_write && (pend_rd != 5'd0);
                    sel_err_nxt       = 1'b0;
                    state_nxt         = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // State, output register and pending-load register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ACCEPT;
            out_valid      <= 1'b0;
            result         <= '0;
            out_rd         <= 5'd0;
            out_reg_write  <= 1'b0;
            sel_err        <= 1'b0;
            pend_rd        <= 5'd0;
            pend_reg_write <= 1'b0;
        end else begin
            state          <= state_nxt;
            out_valid      <= valid_nxt;
            result         <= result_nxt;
            out_rd         <= out_rd_nxt;
            out_reg_write  <= out_reg_write_nxt;
            sel_err        <= sel_err_nxt;
            pend_rd        <= pend_rd_nxt;
            pend_reg_write <= pend_reg_write_nxt;
        end
    end

`ifdef WB_PERF_EN
    // Retired-beat and load-stall cycle counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (out_valid && out_ready) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (state == LOAD_WAIT) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_result_sel.sv
// Testbench for wb_result_sel: directed scenarios plus randomized traffic with
// random backpressure, checked by a queue-based scoreboard and monitor.
module tb_wb_result_sel;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NSRC     = 5;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned LOAD_SRC = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     sel;
    logic [NSRC*XLEN-1:0] src_data;
    logic [XLEN-1:0]      srcs [NSRC];
    logic [4:0]           rd;
    logic                 reg_write;
    logic                 mem_rvalid;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;
    logic [4:0]           out_rd;
    logic                 out_reg_write;
    logic                 sel_err;
`ifdef WB_PERF_EN
    logic [31:0]          perf_retired;
    logic [31:0]          perf_stall;
`endif

    logic bp_mode;
    logic man_ready;
    logic rnd_ready = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        logic            we;
        logic            err;
    } beat_t;

    beat_t exp_q[$];
    int    tests  = 0;
    int    fails  = 0;
    int    popped = 0;

    always #5 clk = ~clk;

    assign out_ready = bp_mode ? rnd_ready : man_ready;

    always_comb begin
        for (int i = 0; i < NSRC; i++) src_data[i*XLEN +: XLEN] = srcs[i];
    end

    wb_result_sel #(
        .XLEN(XLEN), .NSRC(NSRC), .SEL_W(SEL_W), .LOAD_SRC(LOAD_SRC)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_data(src_data), .rd(rd), .reg_write(reg_write),
        .mem_rvalid(mem_rvalid), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .sel_err(sel_err)
`ifdef WB_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    // Random downstream backpressure.
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat for an instruction whose selected source carries v.
    function automatic beat_t model(input logic [SEL_W-1:0] s, input logic [4:0] r,
                                    input logic w, input logic [XLEN-1:0] v);
        beat_t m;
        logic  legal;
        legal = int'(s) < int'(NSRC);
        m.res = legal ? v : '0;
        m.rd  = r;
        m.we  = w && legal && (r != 5'd0);
        m.err = !legal;
        return m;
    endfunction

    // Monitor: compare every consumed beat and check stability while stalled.
    logic  held_v = 1'b0;
    beat_t held_b;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {result, out_rd, out_reg_write, sel_err};
        if (reset) begin
            held_v = 1'b0;
            popped = 0;
        end else begin
            if (held_v && out_valid) begin
                tests++;
                if (cur !== held_b) begin
                    fails++;
                    $display("FAIL hold_stable: got %h expected %h at %0t", cur, held_b, $time);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                popped++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got res=%h rd=%0d at %0t", result, out_rd, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL beat: got res=%h rd=%0d we=%0b err=%0b expected res=%h rd=%0d we=%0b err=%0b",
                                 cur.res, cur.rd, cur.we, cur.err, e.res, e.rd, e.we, e.err);
                    end
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held_v = 1'b1;
                held_b = cur;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Issue one instruction; entered and left just after a rising edge.
    task automatic issue(input logic [SEL_W-1:0] s, input logic [4:0] r, input logic w,
                         input int dly, input logic [XLEN-1:0] v);
        logic is_load;
        int   n;
        is_load = (int'(s) == int'(LOAD_SRC));
        for (int i = 0; i < NSRC; i++) srcs[i] = $urandom;
        if (int'(s) < int'(NSRC) && !(is_load && dly > 0)) srcs[s] = v;
        sel        = s;
        rd         = r;
        reg_write  = w;
        in_valid   = 1'b1;
        mem_rvalid = is_load ? (dly == 0) : 1'($urandom_range(0, 1));
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model(s, r, w, v));
        #1;
        in_valid   = 1'b0;
        sel        = 3'($urandom);
        rd         = 5'($urandom);
        reg_write  = 1'($urandom);
        mem_rvalid = 1'b0;
        for (int i = 0; i < NSRC; i++) srcs[i] = $urandom;
        if (is_load && dly > 0) begin
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                check("load_wait_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
            end
            srcs[LOAD_SRC] = v;
            mem_rvalid     = 1'b1;
            n = 0;
            @(negedge clk);
            while (out_valid && !out_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        sel        = '0;
        rd         = '0;
        reg_write  = 1'b0;
        mem_rvalid = 1'b0;
        bp_mode    = 1'b0;
        man_ready  = 1'b1;
        for (int i = 0; i < NSRC; i++) srcs[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_reg_write", 64'(out_reg_write), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic ALU beat, one-cycle latency.
        issue(3'd0, 5'd5, 1'b1, 0, 32'h0000_00AA);
        @(negedge clk);
        check("alu_out_valid", 64'(out_valid), 64'd1);
        check("alu_result", 64'(result), 64'hAA);
        check("alu_out_reg_write", 64'(out_reg_write), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: second beat waits, first holds, both delivered in order.
        man_ready = 1'b0;
        issue(3'd2, 5'd9, 1'b1, 0, 32'h0000_0104);
        fork
            issue(3'd3, 5'd10, 1'b1, 0, 32'h0000_0200);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_result", 64'(result), 64'h104);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                man_ready = 1'b1;
            end
        join
        @(negedge clk);
        check("bp_second_result", 64'(result), 64'h200);
        @(posedge clk);
        #1;

        // Load waits three cycles for memory data.
        issue(3'd1, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);
        @(negedge clk);
        check("load_result", 64'(result), 64'hDEAD_BEEF);
        check("load_out_rd", 64'(out_rd), 64'd7);
        @(posedge clk);
        #1;

        // Illegal select, then a legal beat.
        issue(3'd6, 5'd3, 1'b1, 0, 32'h5555_AAAA);
        @(negedge clk);
        check("illegal_sel_err", 64'(sel_err), 64'd1);
        check("illegal_result", 64'(result), 64'd0);
        check("illegal_we", 64'(out_reg_write), 64'd0);
        @(posedge clk);
        #1;
        issue(3'd3, 5'd4, 1'b1, 0, 32'h0000_0300);
        @(negedge clk);
        check("legal_after_illegal_err", 64'(sel_err), 64'd0);
        @(posedge clk);
        #1;

        // Write to x0 is suppressed.
        issue(3'd4, 5'd0, 1'b1, 0, 32'h0000_1234);
        @(negedge clk);
        check("x0_result", 64'(result), 64'h1234);
        check("x0_we", 64'(out_reg_write), 64'd0);
        @(posedge clk);
        #1;

        // Reset while a load is pending discards it.
        sel        = 3'd1;
        rd         = 5'd7;
        reg_write  = 1'b1;
        mem_rvalid = 1'b0;
        in_valid   = 1'b1;
        @(negedge clk);
        check("pre_lw_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lw_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_lw_out_valid", 64'(out_valid), 64'd0);
        check("rst_lw_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 mem_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_lw_no_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1 mem_rvalid = 1'b0;

        // Randomized traffic with random backpressure.
        bp_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            logic [SEL_W-1:0] s;
            logic [4:0]       r;
            s = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            issue(s, r, 1'($urandom), int'($urandom_range(0, 3)), $urandom);
        end

        // Drain remaining beats.
        bp_mode   = 1'b0;
        man_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        @(negedge clk);
`ifdef WB_PERF_EN
        check("perf_retired", 64'(perf_retired), 64'(popped));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
